// File: rtl/key_command_encoder.sv
// key_command_encoder: turns key presses into prioritised command codes with auto-repeat,
// queued in a small FIFO behind a valid/ready handshake.  Rev 1.0
`default_nettype none

module key_command_encoder #(
  parameter int                N_KEYS        = 4,
  parameter int                CMD_W         = 3,
  parameter int                REPEAT_DELAY  = 25_000_000,
  parameter int                REPEAT_PERIOD = 5_000_000,
  parameter logic [N_KEYS-1:0] REPEAT_MASK   = 4'b0111,
  parameter int                FIFO_DEPTH    = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [N_KEYS-1:0]                  key,
  output logic                               cmd_valid,
  input  logic                               cmd_ready,
  output logic [CMD_W-1:0]                   cmd,
  output logic                               dropped,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count
);

  localparam int AW      = (N_KEYS > 1) ? $clog2(N_KEYS) : 1;
  localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam int PW      = $clog2(FIFO_DEPTH);
  localparam int CW      = $clog2(FIFO_DEPTH+1);

  typedef enum logic [1:0] {IDLE = 2'd0, DELAY = 2'd1, REPEAT = 2'd2, HOLD = 2'd3} state_t;

  state_t            state_q;
  logic [AW-1:0]     act_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [N_KEYS-1:0] key_q;

  logic [N_KEYS-1:0] rise;
  logic [AW-1:0]     sel;
  logic              held;
  logic              delay_done;
  logic              period_done;
  logic              emit;
  logic [CMD_W-1:0]  emit_code;

  assign rise        = key & ~key_q;
  assign held        = key[act_q];
  assign delay_done  = (cnt_q == CNT_W'(REPEAT_DELAY - 1));
  assign period_done = (cnt_q == CNT_W'(REPEAT_PERIOD - 1));

  // Scanning downward leaves the lowest-index rising key selected.
  always_comb begin
    sel = '0;
    for (int i = N_KEYS - 1; i >= 0; i--) begin
      if (rise[i]) sel = AW'(i);
    end
    emit      = 1'b0;
    emit_code = CMD_W'(act_q) + CMD_W'(1);
    if (|rise) begin
      emit      = 1'b1;
      emit_code = CMD_W'(sel) + CMD_W'(1);
    end else if (state_q == DELAY && held && delay_done) begin
      emit = 1'b1;
    end else if (state_q == REPEAT && held && period_done) begin
      emit = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      act_q   <= '0;
      cnt_q   <= '0;
      key_q   <= '0;
    end else begin
      key_q <= key;
      if (|rise) begin
        act_q   <= sel;
        cnt_q   <= '0;
        state_q <= REPEAT_MASK[sel] ? DELAY : HOLD;
      end else begin
        case (state_q)
          IDLE: state_q <= IDLE;
          DELAY: begin
            if (!held) begin
              state_q <= IDLE;
            end else if (delay_done) begin
              cnt_q   <= '0;
              state_q <= REPEAT;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          REPEAT: begin
            if (!held) begin
              state_q <= IDLE;
            end else if (period_done) begin
              cnt_q <= '0;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          HOLD: if (!held) state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  logic [CMD_W-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]    wr_q, wr_d;
  logic [PW-1:0]    rd_q, rd_d;
  logic [CW-1:0]    count_q, count_d;
  logic [CMD_W-1:0] cmd_q, cmd_d;
  logic             valid_q;
  logic             dropped_q;
  logic             full;
  logic             pop;
  logic             push;

  assign full = (count_q == CW'(FIFO_DEPTH));
  assign pop  = valid_q & cmd_ready;
  assign push = emit & (~full | pop);

  // The head register is fed from the incoming code when that code becomes the sole entry.
  always_comb begin
    wr_d    = push ? wr_q + PW'(1) : wr_q;
    rd_d    = pop  ? rd_q + PW'(1) : rd_q;
    count_d = count_q;
    if (push && !pop) count_d = count_q + CW'(1);
    if (pop && !push) count_d = count_q - CW'(1);
    if (count_d == '0) begin
      cmd_d = '0;
    end else if (push && count_d == CW'(1)) begin
      cmd_d = emit_code;
    end else begin
      cmd_d = mem_q[rd_d];
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= emit_code;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q      <= '0;
      rd_q      <= '0;
      count_q   <= '0;
      cmd_q     <= '0;
      valid_q   <= 1'b0;
      dropped_q <= 1'b0;
    end else begin
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      count_q   <= count_d;
      cmd_q     <= cmd_d;
      valid_q   <= (count_d != '0);
      dropped_q <= emit & full & ~pop;
    end
  end

  assign cmd_valid  = valid_q;
  assign cmd        = cmd_q;
  assign dropped    = dropped_q;
  assign fifo_count = count_q;

endmodule

`default_nettype wire

// File: tb/tb_key_command_encoder.sv
// tb_key_command_encoder: directed stimulus with a queue of expected commands checked at each handshake.
// Rev 1.0
`default_nettype none
`timescale 1ns/1ps

module tb_key_command_encoder;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] key = 4'b0000;
  logic       cmd_ready = 1'b1;
  logic       cmd_valid;
  logic [2:0] cmd;
  logic       dropped;
  logic [2:0] fifo_count;

  always #5 clk = ~clk;

  key_command_encoder #(
    .N_KEYS       (4),
    .CMD_W        (3),
    .REPEAT_DELAY (8),
    .REPEAT_PERIOD(4),
    .REPEAT_MASK  (4'b0111),
    .FIFO_DEPTH   (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key       (key),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd       (cmd),
    .dropped   (dropped),
    .fifo_count(fifo_count)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int drop_cnt  = 0;
  int last_pop  = -100;

  // cyc >= 0: exact handshake cycle; -1: unchecked; -2: must follow previous handshake.
  typedef struct {
    int code;
    int cyc;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string name, input int got, input int exp);
    total_cnt++;
    if (got == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
  endtask

  task automatic expect_cmd(input int code, input int c);
    exp_t e;
    e.code = code;
    e.cyc  = c;
    sb.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (dropped) drop_cnt++;
      if (cmd_valid && cmd_ready) begin
        if (sb.size() == 0) begin
          chk("spurious_cmd", int'(cmd), -1);
        end else begin
          e = sb.pop_front();
          chk("cmd_code", int'(cmd), e.code);
          if (e.cyc >= 0) chk("cmd_cycle", cyc, e.cyc);
          else if (e.cyc == -2) chk("drain_rate", cyc, last_pop + 1);
        end
        last_pop = cyc;
      end
    end
  end

  initial begin
    int t0;
    #1 rst = 1'b1;
    tick(2);
    chk("rst_cmd_valid", int'(cmd_valid), 0);
    chk("rst_cmd", int'(cmd), 0);
    chk("rst_fifo_count", int'(fifo_count), 0);
    chk("rst_dropped", int'(dropped), 0);
    rst = 1'b0;
    tick(2);

    // Single tap, no repeat
    key = 4'b0001; t0 = cyc + 1;
    expect_cmd(1, t0);
    tick(3); key = 4'b0000; tick(14);
    chk("tap_sb_empty", sb.size(), 0);

    // Hold with auto-repeat
    key = 4'b0010; t0 = cyc + 1;
    expect_cmd(2, t0); expect_cmd(2, t0 + 8); expect_cmd(2, t0 + 12); expect_cmd(2, t0 + 16);
    tick(20); key = 4'b0000; tick(14);
    chk("hold_sb_empty", sb.size(), 0);

    // Priority between simultaneous presses
    key = 4'b1100; t0 = cyc + 1;
    expect_cmd(3, t0);
    tick(2); key = 4'b0000; tick(14);
    chk("prio_sb_empty", sb.size(), 0);

    // Non-repeating key held long
    key = 4'b1000; t0 = cyc + 1;
    expect_cmd(4, t0);
    tick(30); key = 4'b0000; tick(4);
    chk("norep_sb_empty", sb.size(), 0);

    // Preemption by a later press
    key = 4'b0001; t0 = cyc + 1;
    expect_cmd(1, t0);
    tick(5);
    key = 4'b0011;
    expect_cmd(2, t0 + 5); expect_cmd(2, t0 + 13); expect_cmd(2, t0 + 17);
    tick(14); key = 4'b0000; tick(14);
    chk("preempt_sb_empty", sb.size(), 0);

    // Backpressure and overflow
    cmd_ready = 1'b0; drop_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      key = 4'(1 << (i % 4));
      if (i < 4) expect_cmd(i + 1, (i == 0) ? -1 : -2);
      tick(1); key = 4'b0000; tick(1);
      if (i >= 1) chk("bp_head_stable", int'(cmd), 1);
      if (i == 3) chk("bp_no_drop_yet", drop_cnt, 0);
    end
    chk("bp_fifo_count", int'(fifo_count), 4);
    chk("bp_drop_once", drop_cnt, 1);
    chk("bp_valid", int'(cmd_valid), 1);
    cmd_ready = 1'b1;
    tick(6);
    chk("drain_fifo_count", int'(fifo_count), 0);
    chk("drain_valid", int'(cmd_valid), 0);
    chk("drain_sb_empty", sb.size(), 0);

    // Reset flushes queued commands
    cmd_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      key = 4'(1 << i);
      tick(1); key = 4'b0000; tick(1);
    end
    chk("flush_pre_count", int'(fifo_count), 3);
    #1 rst = 1'b1;
    #1;
    chk("flush_valid", int'(cmd_valid), 0);
    chk("flush_count", int'(fifo_count), 0);
    chk("flush_cmd", int'(cmd), 0);

    // Key held across reset release counts as a press
    key = 4'b0001; cmd_ready = 1'b1;
    tick(2);
    rst = 1'b0; t0 = cyc + 1;
    expect_cmd(1, t0);
    tick(2); key = 4'b0000; tick(14);
    chk("rstkey_sb_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

`default_nettype wire
